fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the DAPA2014 processor. Drives the address of the combinational program memory, captures the returned 16-bit instruction word into an instruction register, and presents it to decode through a valid/ready handshake. Owns the program counter, applies branch redirects from decode, and halts fetch on a STOP opcode.

## Interface
- PC_W, 8, program-counter and memory-address width
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC value after reset
- clk  input  1  single system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- addr  output  PC_W  program-memory address; combinationally equal to PC
- data  input  INSTR_W  instruction word from program memory, valid in the same cycle as addr
- instr  output  INSTR_W  registered instruction to decode
- instr_pc  output  PC_W  address from which instr was fetched
- instr_valid  output  1  instr/instr_pc hold a live instruction
- instr_ready  input  1  decode accepts instr this cycle
- br_take  input  1  redirect request from decode, single-cycle pulse
- br_target  input  PC_W  redirect address, sampled when br_take=1
- resume  input  1  single-cycle pulse that leaves HALT
- halted  output  1  fetch is stopped on a STOP

## Operation
- States: FETCH, HALT. Reset state FETCH.
- Reset values: PC=RESET_PC, addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0.
- Load condition: state FETCH and (instr_valid=0 or instr_ready=1). On load, in one edge: instr<=data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
- Stall: instr_valid=1 and instr_ready=0. instr, instr_pc, instr_valid and PC hold.
- Consume without refill (state HALT and instr_ready=1): instr_valid<=0.
- PC arithmetic is modulo 2^PC_W: 8'hFF+1 = 8'h00, with no flag.
- STOP is data[15:11]=5'b10111. When a loaded word is STOP: the word is presented normally, PC is not incremented (stays at the STOP address), and state<=HALT. halted=1 exactly while in HALT.
- HALT: no loads, addr holds the STOP address. resume=1 sets PC<=PC+1 and state<=FETCH. resume in FETCH is ignored.
- br_take has the highest priority in every state: PC<=br_target, instr_valid<=0 (flush, including a presented STOP), state<=FETCH, halted<=0. A load that would otherwise occur in the same cycle is discarded.
- br_take and resume in the same cycle: br_take wins.
- Async reset mid-operation returns every output to its reset value immediately, independent of clk.

## Timing
- addr to data is combinational. One cycle from address to instr_valid.
- Throughput is one instruction per cycle while instr_ready=1.
- Redirect: br_take at edge N. addr=br_target after N. instr_valid=0 during cycle N+1. The target instruction is valid after N+1.
- STOP loaded at edge N: halted=1 after N. addr is frozen from N onward.
- Handshake: a transfer occurs on any edge where instr_valid=1 and instr_ready=1. instr_valid never drops without a transfer, flush or reset.

## Configuration
- FETCH_HALT_EN defined: STOP detection, HALT state, halted and resume behave as above.
- FETCH_HALT_EN undefined: STOP is an ordinary instruction and PC increments past it. The state machine has FETCH only. halted is tied to 0 and resume is ignored.

## Structure
- Package fetch_pkg holds PC_W/INSTR_W defaults, OPC_STOP=5'b10111, the opcode field slice [15:11], and the fetch_state_t enum {FETCH, HALT}.
- Sub-module fetch_pc contains the PC register, incrementer and redirect/hold mux, with inputs inc, load and target.
- The instruction register and the state machine stay in fetch_unit.

## Test plan
- Reset, then memory holds 0:F8AA, 1:1080, 2:B800, with instr_ready=1. Successive edges present F8AA/pc0, 1080/pc1, B800/pc2. halted=1 after the third edge and addr stays 2.
- Backpressure: hold instr_ready=0 for 3 cycles with F8AA presented. instr and instr_pc stay stable and addr=1. Raising instr_ready presents 1080 on the next edge.
- Redirect: assert br_take with br_target=8'h40 while instr_valid=1. The next cycle has instr_valid=0 and addr=8'h40. The cycle after presents instr_pc=8'h40.
- Wrap: redirect to 8'hFF. The word is loaded with instr_pc=8'hFF and addr becomes 8'h00.
- Halt exit: a resume pulse in HALT gives addr=3 and fetching continues. Separately, br_take and resume together in HALT give addr=br_target. With FETCH_HALT_EN undefined, B800 passes and addr reaches 3 with halted=0.
- Assert rst_n low asynchronously mid-stream. All outputs go to reset values before the next clk edge, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, STOP opcode encoding and fetch state type for
//               the DAPA2014 instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FETCH_PC_W    = 8;
  localparam int FETCH_INSTR_W = 16;

  // Opcode field position inside an instruction word
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;

  localparam logic [OPC_HI-OPC_LO:0] OPC_STOP = 5'b10111;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  // Extract the opcode field of a 16-bit instruction word
  function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [FETCH_INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter register with incrementer and redirect/hold
//               mux. load has priority over inc; arithmetic wraps modulo
//               2^PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Next PC: redirect wins over sequential advance, otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + PC_ONE;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Drives the program-memory address
//               from the PC, registers the returned word and hands it to
//               decode over a valid/ready handshake. Branch redirects from
//               decode flush the presented instruction.
//               Define FETCH_HALT_EN to enable STOP detection, the HALT state,
//               the halted output and resume; otherwise STOP is an ordinary
//               instruction and halted is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INSTR_W  = FETCH_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    addr,
  input  logic [INSTR_W-1:0] data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_take,
  input  logic [PC_W-1:0]    br_target,
  input  logic               resume,
  output logic               halted
);

  fetch_state_t       state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    instr_pc_d, instr_pc_q;
  logic               instr_valid_d, instr_valid_q;

  logic               pc_inc;
  logic               pc_load;
  logic [PC_W-1:0]    pc;
  logic               stop_hit;

`ifdef FETCH_HALT_EN
  assign stop_hit = (opcode_of(data[FETCH_INSTR_W-1:0]) == OPC_STOP);
  assign halted   = (state_q == HALT);
`else
  assign stop_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  fetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (br_target),
    .pc     (pc)
  );

  // Next-state, instruction register update and PC control
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;

    if (br_take) begin
      // Redirect flushes whatever is presented, including a STOP
      pc_load       = 1'b1;
      instr_valid_d = 1'b0;
      state_d       = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (!instr_valid_q || instr_ready) begin
            instr_d       = data;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            // A STOP keeps the PC parked on its own address
            if (stop_hit) begin
              state_d = HALT;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        HALT: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
          end
          if (resume) begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign addr        = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios then
//               randomized traffic, compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_take;
  logic [7:0]  br_target;
  logic        resume;
  logic        halted;

  logic [15:0] mem [256];

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Behavioural model of the visible fetch state
  logic [7:0]  m_pc;
  logic [7:0]  m_ipc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_halt;

  always #5 clk = ~clk;

  assign data = mem[addr];

  fetch_unit #(
    .PC_W     (8),
    .INSTR_W  (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .data        (data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_take     (br_take),
    .br_target   (br_target),
    .resume      (resume),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc    = 8'h00;
    m_ipc   = 8'h00;
    m_instr = 16'h0000;
    m_valid = 1'b0;
    m_halt  = 1'b0;
  endtask

  // One clock edge worth of fetch behaviour, from the rules of the stage
  task automatic model_edge(input logic rdy, input logic br, input logic [7:0] tgt, input logic res);
    logic [15:0] w;
    if (br) begin
      m_pc    = tgt;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (!m_halt) begin
      if (!m_valid || rdy) begin
        w       = mem[m_pc];
        m_instr = w;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        if (HALT_EN && (w[15:11] == 5'b10111)) m_halt = 1'b1;
        else                                   m_pc   = m_pc + 8'd1;
      end
    end else begin
      if (rdy) m_valid = 1'b0;
      if (res) begin
        m_pc   = m_pc + 8'd1;
        m_halt = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".addr"},     {8'h00, addr},      {8'h00, m_pc});
    chk({tag, ".valid"},    {15'h0, instr_valid}, {15'h0, m_valid});
    chk({tag, ".instr"},    instr,              m_instr);
    chk({tag, ".instr_pc"}, {8'h00, instr_pc},  {8'h00, m_ipc});
    chk({tag, ".halted"},   {15'h0, halted},    {15'h0, m_halt});
  endtask

  // Apply inputs across one rising edge, then check just after it
  task automatic cyc(input string tag, input logic rdy, input logic br, input logic [7:0] tgt, input logic res);
    instr_ready = rdy;
    br_take     = br;
    br_target   = tgt;
    resume      = res;
    @(posedge clk);
    model_edge(rdy, br, tgt, res);
    #1;
    compare_all(tag);
    br_take = 1'b0;
    resume  = 1'b0;
  endtask

  // Reset asserted between edges; outputs must react without a clock edge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    br_take     = 1'b0;
    br_target   = 8'h00;
    resume      = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 + 16'(i);
    mem[0]     = 16'hF8AA;
    mem[1]     = 16'h1080;
    mem[2]     = 16'hB800;
    mem[8'h40] = 16'h4040;
    mem[8'hFF] = 16'h7FFF;
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;

    // Straight-line program ending in STOP
    cyc("seq0", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("seq0.word", instr, 16'hF8AA);
    cyc("seq1", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("seq1.word", instr, 16'h1080);
    cyc("seq2", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("seq2.word", instr, 16'hB800);
    chk("seq2.pc", {8'h00, instr_pc}, 16'h0002);
    chk("seq2.addr", {8'h00, addr}, HALT_EN ? 16'h0002 : 16'h0003);
    cyc("hold0", 1'b1, 1'b0, 8'h00, 1'b0);
    cyc("hold1", 1'b1, 1'b0, 8'h00, 1'b0);
    cyc("resume", 1'b1, 1'b0, 8'h00, 1'b1);
    cyc("after_res", 1'b1, 1'b0, 8'h00, 1'b0);

    // Backpressure with F8AA presented
    do_reset("rst2");
    cyc("bp_load", 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("bp_stall", 1'b0, 1'b0, 8'h00, 1'b0);
      chk("bp_stall.word", instr, 16'hF8AA);
      chk("bp_stall.addr", {8'h00, addr}, 16'h0001);
    end
    cyc("bp_go", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("bp_go.word", instr, 16'h1080);

    // Redirect while valid
    cyc("br", 1'b1, 1'b1, 8'h40, 1'b0);
    chk("br.valid", {15'h0, instr_valid}, 16'h0000);
    chk("br.addr", {8'h00, addr}, 16'h0040);
    cyc("br_tgt", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("br_tgt.pc", {8'h00, instr_pc}, 16'h0040);

    // Wrap at the top of the address space
    cyc("wrap_br", 1'b1, 1'b1, 8'hFF, 1'b0);
    cyc("wrap", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("wrap.pc", {8'h00, instr_pc}, 16'h00FF);
    chk("wrap.addr", {8'h00, addr}, 16'h0000);

    // Redirect and resume together while halted
    do_reset("rst3");
    for (int i = 0; i < 3; i++) cyc("to_stop", 1'b0, 1'b0, 8'h00, 1'b0);
    cyc("to_stop_rdy", 1'b1, 1'b0, 8'h00, 1'b0);
    cyc("to_stop_rdy", 1'b1, 1'b0, 8'h00, 1'b0);
    cyc("br_res", 1'b1, 1'b1, 8'h80, 1'b1);
    chk("br_res.addr", {8'h00, addr}, 16'h0080);
    cyc("br_res_next", 1'b1, 1'b0, 8'h00, 1'b0);

    // Async reset mid-stream, then restart from RESET_PC
    cyc("pre_ar", 1'b1, 1'b0, 8'h00, 1'b0);
    do_reset("async_rst");
    cyc("post_ar", 1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_ar.pc", {8'h00, instr_pc}, 16'h0000);

    // Randomized traffic with sprinkled STOP words
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(7) == 0) w[15:11] = 5'b10111;
      mem[i] = w;
    end
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          ($urandom_range(3) != 0),
          ($urandom_range(15) == 0),
          8'($urandom),
          ($urandom_range(5) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire
